sprite_table_ctrl: RTL and testbench
====================================

// Module: sprite_table_ctrl
// PURPOSE
//  Owns the sprite/object table that drives the display renderer's gamedata bus.
//  Two game-logic requesters (0 = dinosaur/player, 1 = obstacle spawner) write entries into a shadow table.
//  Writes are arbitrated round-robin, one write per cycle.
//  On a commit, the shadow table is copied into the active table only at the start of the next vertical sync pulse.
//  The renderer therefore never sees a half-updated frame.
// PARAMETERS
//  DATACOUNT  8   number of table entries (slots)
//  IDXW       4   index width per requester; must be >= clog2(DATACOUNT)
//  TYPEW      3   type field width; 0 = empty slot, n = image n-1
//  XW         10  x field width
//  YW         9   y field width
//  WW         10  width field width
//  HW         9   height field width
//  DATALEN    TYPEW+XW+YW+WW+HW  entry width (derived; do not override)
// PORTS
//  clock       in   1                clock, pixel clock domain
//  reset       in   1                asynchronous, active-low
//  frame_sync  in   1                vertical sync from renderer, active-low, synchronous to clock
//  req_valid   in   2                per-requester write request
//  req_ready   out  2                per-requester grant; write completes when valid&&ready
//  req_index   in   2*IDXW           slot index; requester r uses [r*IDXW +: IDXW]
//  req_entry   in   2*DATALEN        entry; requester r uses [r*DATALEN +: DATALEN]
//  commit_req  in   1                single-cycle pulse: shadow complete, publish at next frame
//  gamedata    out  DATACOUNT*DATALEN  active table; slot i at [i*DATALEN +: DATALEN]
//  commit_pend out  1                high while a commit waits for frame start
//  swap_done   out  1                one-cycle pulse after the active table updates
//  wr_error    out  1                one-cycle pulse: accepted write had index >= DATACOUNT
// BEHAVIOUR
//  Entry layout, LSB first: type[TYPEW], x[XW], y[YW], w[WW], h[HW].
//  Reset (async, !reset): shadow and active tables all zero (all slots empty).
//    Also cleared by reset: state=OPEN, last_grant=1, sync_q=1, commit_pend=0, swap_done=0, wr_error=0.
//  frame_start (combinational) = sync_q && !frame_sync; sync_q <= frame_sync every cycle.
//  FSM states:
//   OPEN:
//    - Grant goes to the requester whose valid is high. If both are valid, grant the one != last_grant.
//    - req_ready is combinational: req_ready[g] = (state==OPEN) && req_valid[g]; at most one bit is high.
//    - On a handshake, shadow[index] <= entry at the clock edge and last_grant <= g.
//    - If index >= DATACOUNT, the handshake still completes, the shadow is unchanged, and wr_error pulses next cycle.
//    - commit_req -> PENDING; commit_pend <= 1.
//    - A write in the same cycle as commit_req is accepted and included in the commit.
//   PENDING:
//    - req_ready = 0; all writes are stalled, none dropped.
//    - commit_req is ignored.
//    - frame_start -> SWAP.
//    - frame_start detection stays armed regardless of state. A frame_start in the same cycle as the OPEN->PENDING transition is missed; the swap waits for the following frame.
//   SWAP (exactly 1 cycle):
//    - active <= shadow (all slots in parallel).
//    - commit_pend <= 0; swap_done <= 1 for one cycle.
//    - Next state -> OPEN; req_ready = 0 during SWAP.
//  Latency: with frame_sync first sampled low at edge N, the state is SWAP after edge N.
//    At edge N+1, gamedata updates, swap_done goes high and writes reopen.
//  gamedata is driven only from the active register; it changes only at SWAP.
//  Shadow is never cleared by a swap, so updates are incremental. To remove an object, write type=0.
//  Fields are stored verbatim; no range clipping (the renderer handles off-screen).
//  frame_sync held low, or frame_start while OPEN: no effect.
//  Reset mid-PENDING/SWAP: the table is zeroed and any pending commit is lost.
// TESTING
//  T1 reset: hold reset=0 -> gamedata==0, commit_pend=0, swap_done=0; release with req_valid=0 -> req_ready=0.
//  T2 publish:
//   - req0 writes idx2 {type1,x100,y200,w40,h40}, then commit_req -> gamedata unchanged and commit_pend=1.
//   - Drive frame_sync 1->0 -> slot2 equals the entry at edge N+1, swap_done is a 1-cycle pulse, and commit_pend=0.
//  T3 arbitration:
//   - req_valid=2'b11 held for 4 cycles -> grants 0,1,0,1 after reset.
//   - Single requester valid -> granted every cycle.
//  T4 stall: commit, then req1 valid during PENDING -> req_ready=0 until the cycle after SWAP; the write then lands in the shadow, not active.
//  T5 bad index: req0 idx 9 (DATACOUNT=8) -> handshake completes, wr_error pulses once, and both tables are unchanged after the next swap.
//  T6 reset mid-op:
//   - Commit pending, assert reset -> gamedata=0 and commit_pend=0.
//   - Following frame_sync edge -> no swap_done.

Source files
------------

// File: rtl/sprite_table_ctrl.sv
// rtl/sprite_table_ctrl.sv - double-buffered sprite table with round-robin writers and vsync-aligned commit
module sprite_table_ctrl #(
  parameter  int DATACOUNT = 8,
  parameter  int IDXW      = 4,
  parameter  int TYPEW     = 3,
  parameter  int XW        = 10,
  parameter  int YW        = 9,
  parameter  int WW        = 10,
  parameter  int HW        = 9,
  localparam int DATALEN   = TYPEW + XW + YW + WW + HW
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           frame_sync,
  input  logic [1:0]                     req_valid,
  output logic [1:0]                     req_ready,
  input  logic [2*IDXW-1:0]              req_index,
  input  logic [2*DATALEN-1:0]           req_entry,
  input  logic                           commit_req,
  output logic [DATACOUNT*DATALEN-1:0]   gamedata,
  output logic                           commit_pend,
  output logic                           swap_done,
  output logic                           wr_error
);
  localparam int SLOTW = (DATACOUNT > 1) ? $clog2(DATACOUNT) : 1;

  typedef enum logic [1:0] {OPEN, PENDING, SWAP} state_t;

  state_t                 state, state_next;
  logic                   last_grant, sync_q, frame_start;
  logic                   grant, grant_valid, wr_in_range;
  logic [IDXW-1:0]        wr_index;
  logic [DATALEN-1:0]     wr_entry;
  logic [DATALEN-1:0]     shadow [DATACOUNT];
  logic [DATALEN-1:0]     active [DATACOUNT];

  // frame_sync is active-low: the frame begins on its falling edge
  assign frame_start = sync_q && !frame_sync;

  always_comb begin
    grant = 1'b0;
    if (req_valid == 2'b11) grant = ~last_grant;
    else                    grant = req_valid[1];
  end

  assign grant_valid = (state == OPEN) && (req_valid != 2'b00);
  assign req_ready   = grant_valid ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign wr_index    = grant ? req_index[IDXW +: IDXW] : req_index[0 +: IDXW];
  assign wr_entry    = grant ? req_entry[DATALEN +: DATALEN] : req_entry[0 +: DATALEN];
  assign wr_in_range = 32'(wr_index) < DATACOUNT;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= OPEN;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      OPEN:    if (commit_req)  state_next = PENDING;
      PENDING: if (frame_start) state_next = SWAP;
      SWAP:                     state_next = OPEN;
      default:                  state_next = OPEN;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_grant  <= 1'b1;
      sync_q      <= 1'b1;
      commit_pend <= 1'b0;
      swap_done   <= 1'b0;
      wr_error    <= 1'b0;
      for (int i = 0; i < DATACOUNT; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      sync_q    <= frame_sync;
      swap_done <= 1'b0;
      wr_error  <= 1'b0;
      if (grant_valid) begin
        last_grant <= grant;
        if (wr_in_range) shadow[wr_index[SLOTW-1:0]] <= wr_entry;
        else             wr_error <= 1'b1;
      end
      if (state == OPEN && commit_req) commit_pend <= 1'b1;
      // shadow is kept after the copy so later frames are incremental edits
      if (state == SWAP) begin
        for (int i = 0; i < DATACOUNT; i++) active[i] <= shadow[i];
        commit_pend <= 1'b0;
        swap_done   <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < DATACOUNT; gi++) begin : g_out
    assign gamedata[gi*DATALEN +: DATALEN] = active[gi];
  end
endmodule

// File: tb/tb_sprite_table_ctrl.sv
// tb/tb_sprite_table_ctrl.sv - self-checking bench for sprite_table_ctrl
module tb_sprite_table_ctrl;
  localparam int DC = 8;
  localparam int IW = 4;
  localparam int DL = 41;
  localparam int GW = DC * DL;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            frame_sync = 1'b1;
  logic            commit_req = 1'b0;
  logic [1:0]      req_valid = 2'b00;
  logic [1:0]      req_ready;
  logic [2*IW-1:0] req_index = '0;
  logic [2*DL-1:0] req_entry = '0;
  logic [GW-1:0]   gamedata;
  logic            commit_pend, swap_done, wr_error;

  int checks = 0;
  int errors = 0;

  sprite_table_ctrl dut (
    .clock(clock), .reset(reset), .frame_sync(frame_sync),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_index(req_index), .req_entry(req_entry),
    .commit_req(commit_req), .gamedata(gamedata),
    .commit_pend(commit_pend), .swap_done(swap_done), .wr_error(wr_error)
  );

  always #5 clock = ~clock;

  // reference: two plain arrays plus "commit waiting" / "swap on next edge" flags
  logic [DL-1:0] m_shadow [DC];
  logic [DL-1:0] m_active [DC];
  bit m_waiting, m_swap_now, m_prev_sync, m_prefer, m_done, m_err;

  typedef struct {
    logic [1:0] valid;
    int         i0;
    int         i1;
    logic [1:0] exp_ready;
  } vec_t;
  vec_t vecs [8];

  function automatic logic [DL-1:0] mk(input int t, input int x, input int y, input int w, input int h);
    return {h[8:0], w[9:0], y[8:0], x[9:0], t[2:0]};
  endfunction

  function automatic logic [DL-1:0] rnd_entry();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[DL-1:0];
  endfunction

  function automatic logic [GW-1:0] m_pack();
    logic [GW-1:0] p;
    for (int i = 0; i < DC; i++) p[i*DL +: DL] = m_active[i];
    return p;
  endfunction

  function automatic logic [1:0] m_ready();
    if (m_waiting || req_valid == 2'b00) return 2'b00;
    if (req_valid == 2'b11) return m_prefer ? 2'b10 : 2'b01;
    return req_valid;
  endfunction

  task automatic chk(input string name, input logic [GW-1:0] act, input logic [GW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DC; i++) begin
      m_shadow[i] = '0;
      m_active[i] = '0;
    end
    m_waiting = 0; m_swap_now = 0; m_prev_sync = 1;
    m_prefer = 0; m_done = 0; m_err = 0;
  endtask

  task automatic model_step();
    logic [1:0]    r;
    int            g;
    int            idx;
    logic [DL-1:0] e;
    bit            fstart;
    r = m_ready();
    fstart = m_prev_sync && !frame_sync;
    m_done = 0;
    m_err  = 0;
    if (r != 2'b00) begin
      g   = r[1] ? 1 : 0;
      idx = int'(req_index[g*IW +: IW]);
      e   = req_entry[g*DL +: DL];
      if (idx < DC) m_shadow[idx] = e;
      else          m_err = 1;
      m_prefer = (g == 0);
    end
    if (m_swap_now) begin
      for (int i = 0; i < DC; i++) m_active[i] = m_shadow[i];
      m_waiting = 0; m_swap_now = 0; m_done = 1;
    end else if (m_waiting && fstart) begin
      m_swap_now = 1;
    end else if (!m_waiting && commit_req) begin
      m_waiting = 1;
    end
    m_prev_sync = frame_sync;
  endtask

  task automatic drive(input logic [1:0] v, input int i0, input int i1,
                       input logic [DL-1:0] e0, input logic [DL-1:0] e1,
                       input logic c, input logic fs);
    req_valid  = v;
    req_index  = {i1[IW-1:0], i0[IW-1:0]};
    req_entry  = {e1, e0};
    commit_req = c;
    frame_sync = fs;
  endtask

  task automatic tick();
    #1;
    chk("req_ready", req_ready, m_ready());
    @(posedge clock);
    model_step();
    #1;
    chk("gamedata", gamedata, m_pack());
    chk("commit_pend", commit_pend, m_waiting);
    chk("swap_done", swap_done, m_done);
    chk("wr_error", wr_error, m_err);
  endtask

  task automatic do_swap();
    drive(2'b00, 0, 0, '0, '0, 1'b1, 1'b1); tick();
    drive(2'b00, 0, 0, '0, '0, 1'b0, 1'b0); tick();
    drive(2'b00, 0, 0, '0, '0, 1'b0, 1'b1); tick();
  endtask

  initial begin
    logic [DL-1:0] e2, e4, e5;
    logic [GW-1:0] snap;

    vecs[0] = '{2'b11, 0, 4, 2'b01};
    vecs[1] = '{2'b11, 1, 5, 2'b10};
    vecs[2] = '{2'b11, 2, 6, 2'b01};
    vecs[3] = '{2'b11, 3, 4, 2'b10};
    vecs[4] = '{2'b01, 0, 5, 2'b01};
    vecs[5] = '{2'b01, 1, 6, 2'b01};
    vecs[6] = '{2'b10, 2, 4, 2'b10};
    vecs[7] = '{2'b00, 3, 5, 2'b00};

    // T1: reset
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_gamedata", gamedata, '0);
    chk("rst_commit_pend", commit_pend, 0);
    chk("rst_swap_done", swap_done, 0);
    reset = 1'b1;
    drive(2'b00, 0, 0, '0, '0, 1'b0, 1'b1);
    #1;
    chk("rst_ready", req_ready, 2'b00);

    // T3: arbitration table, fresh from reset
    for (int k = 0; k < 8; k++) begin
      drive(vecs[k].valid, vecs[k].i0, vecs[k].i1, rnd_entry(), rnd_entry(), 1'b0, 1'b1);
      #1;
      chk($sformatf("arb%0d", k), req_ready, vecs[k].exp_ready);
      tick();
    end

    // T2: publish aligned to frame start
    e2 = mk(1, 100, 200, 40, 40);
    drive(2'b01, 2, 0, e2, '0, 1'b0, 1'b1); tick();
    snap = gamedata;
    drive(2'b00, 0, 0, '0, '0, 1'b1, 1'b1); tick();
    chk("t2_unchanged", gamedata, snap);
    chk("t2_pend", commit_pend, 1);
    drive(2'b00, 0, 0, '0, '0, 1'b0, 1'b0); tick();
    chk("t2_no_early_done", swap_done, 0);
    chk("t2_still_unchanged", gamedata, snap);
    tick();
    chk("t2_slot2", gamedata[2*DL +: DL], e2);
    chk("t2_done", swap_done, 1);
    chk("t2_pend_clr", commit_pend, 0);
    drive(2'b00, 0, 0, '0, '0, 1'b0, 1'b1); tick();
    chk("t2_done_pulse", swap_done, 0);

    // T4: writes stall while a commit is pending
    e4 = mk(5, 640, 480, 16, 16);
    drive(2'b00, 0, 0, '0, '0, 1'b1, 1'b1); tick();
    drive(2'b10, 0, 7, '0, e4, 1'b0, 1'b1);
    #1; chk("t4_stall", req_ready, 2'b00);
    tick(); tick();
    frame_sync = 1'b0;
    tick();
    frame_sync = 1'b1;
    #1; chk("t4_stall_swap", req_ready, 2'b00);
    tick();
    chk("t4_swap_done", swap_done, 1);
    #1; chk("t4_reopen", req_ready, 2'b10);
    tick();
    drive(2'b00, 0, 0, '0, '0, 1'b0, 1'b1); tick();
    chk("t4_not_active", gamedata[7*DL +: DL], '0);
    do_swap();
    chk("t4_next_frame", gamedata[7*DL +: DL], e4);

    // T5: out-of-range index
    e5 = mk(7, 1023, 511, 1023, 511);
    snap = gamedata;
    drive(2'b01, 9, 0, e5, '0, 1'b0, 1'b1);
    #1; chk("t5_ready", req_ready, 2'b01);
    tick();
    chk("t5_err", wr_error, 1);
    drive(2'b00, 0, 0, '0, '0, 1'b0, 1'b1); tick();
    chk("t5_err_pulse", wr_error, 0);
    do_swap();
    chk("t5_swap", swap_done, 1);
    chk("t5_unchanged", gamedata, snap);

    // randomized traffic against the reference
    for (int n = 0; n < 400; n++) begin
      drive(2'($urandom_range(0, 3)), $urandom_range(0, 11), $urandom_range(0, 11),
            rnd_entry(), rnd_entry(), $urandom_range(0, 7) == 0, $urandom_range(0, 5) != 0);
      tick();
    end

    // T6: reset while a commit is pending
    drive(2'b00, 0, 0, '0, '0, 1'b0, 1'b1); tick(); tick();
    drive(2'b00, 0, 0, '0, '0, 1'b1, 1'b1); tick();
    chk("t6_pend", commit_pend, 1);
    drive(2'b00, 0, 0, '0, '0, 1'b0, 1'b1);
    reset = 1'b0;
    #2;
    model_reset();
    chk("t6_gamedata", gamedata, '0);
    chk("t6_pend_clr", commit_pend, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;
    drive(2'b00, 0, 0, '0, '0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("t6_no_swap%0d", k), swap_done, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
